// File: rtl/core_ctrl.sv
// Instruction sequencer for a single core: weight-stationary passes per kernel
// position followed by one SFP accumulation pass over every stored psum.
module core_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [3:0]         kij_num,
  input  logic [cnt_bw-1:0]  nact,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WPUSH, S_XLOAD, S_EXEC, S_DRAIN, S_ACC, S_DONE
  } state_t;

  localparam logic [34:0]       IDLE_INST   = 35'h1_800C_0000;
  localparam logic [cnt_bw-1:0] C_ONE       = cnt_bw'(1);
  localparam logic [cnt_bw-1:0] C_ROW       = cnt_bw'(row);
  localparam logic [cnt_bw-1:0] C_PUSH_LAST = cnt_bw'(row + col - 1);

  state_t             r_state, w_state_d;
  logic [cnt_bw-1:0]  r_i, w_i_d;
  logic [cnt_bw-1:0]  r_j, w_j_d;
  logic [3:0]         r_k, w_k_d;
  logic [34:0]        r_inst, w_inst_d;
  logic               w_latch, w_drain_rd;

  logic               r_mode;
  logic [3:0]         r_kij;
  logic [cnt_bw-1:0]  r_nact;
  logic [addr_bw-1:0] r_wb, r_xb, r_pb;

  logic               w_mode_d;
  logic [3:0]         w_kij_in, w_kij_last;
  logic [cnt_bw-1:0]  w_nact_in, w_nact_d;
  logic [addr_bw-1:0] w_wb_d, w_xb_d, w_pb_d;

  // Zero-length requests degrade to a single kernel position / vector.
  assign w_kij_in   = (kij_num == 4'd0) ? 4'd1 : kij_num;
  assign w_nact_in  = (nact == '0) ? C_ONE : nact;
  assign w_kij_last = r_kij - 4'd1;

  assign w_mode_d = w_latch ? mode      : r_mode;
  assign w_nact_d = w_latch ? w_nact_in : r_nact;
  assign w_wb_d   = w_latch ? w_base    : r_wb;
  assign w_xb_d   = w_latch ? x_base    : r_xb;
  assign w_pb_d   = w_latch ? p_base    : r_pb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_inst  <= IDLE_INST;
    end else begin
      r_state <= w_state_d;
      r_i     <= w_i_d;
      r_j     <= w_j_d;
      r_k     <= w_k_d;
      r_inst  <= w_inst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_mode <= mode;
      r_kij  <= w_kij_in;
      r_nact <= w_nact_in;
      r_wb   <= w_base;
      r_xb   <= x_base;
      r_pb   <= p_base;
    end
  end

  // In ACC, r_i walks the activation index and r_k the kernel position.
  always_comb begin
    w_state_d  = r_state;
    w_i_d      = r_i + C_ONE;
    w_j_d      = r_j;
    w_k_d      = r_k;
    w_latch    = 1'b0;
    w_drain_rd = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_i_d = '0;
        if (start) begin
          w_latch   = 1'b1;
          w_state_d = S_WLOAD;
          w_k_d     = '0;
          w_j_d     = '0;
        end
      end
      S_WLOAD: if (r_i == C_ROW) begin
        w_state_d = S_WPUSH;
        w_i_d     = '0;
      end
      S_WPUSH: if (r_i == C_PUSH_LAST) begin
        w_state_d = S_XLOAD;
        w_i_d     = '0;
      end
      S_XLOAD: if (r_i == r_nact) begin
        w_state_d = S_EXEC;
        w_i_d     = '0;
      end
      S_EXEC: if (r_i == r_nact - C_ONE) begin
        w_state_d = S_DRAIN;
        w_i_d     = '0;
        w_j_d     = '0;
      end
      S_DRAIN: begin
        w_i_d = '0;
        if (r_j == r_nact) begin
          w_j_d = '0;
          if (r_k == w_kij_last) begin
            w_state_d = S_ACC;
            w_k_d     = '0;
          end else begin
            w_state_d = S_WLOAD;
            w_k_d     = r_k + 4'd1;
          end
        end else if (valid) begin
          w_drain_rd = 1'b1;
          w_j_d      = r_j + C_ONE;
        end
      end
      S_ACC: begin
        w_i_d = r_i;
        if (r_k == w_kij_last) begin
          w_k_d = '0;
          if (r_i == r_nact - C_ONE) begin
            w_state_d = S_DONE;
            w_i_d     = '0;
          end else begin
            w_i_d = r_i + C_ONE;
          end
        end else begin
          w_k_d = r_k + 4'd1;
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
        w_i_d     = '0;
      end
      default: begin
        w_state_d = S_IDLE;
        w_i_d     = '0;
      end
    endcase
  end

  // The instruction is built from the upcoming state so that the registered
  // word lines up with the phase counters of the cycle it drives.
  always_comb begin
    w_inst_d = IDLE_INST;
    if (w_state_d != S_IDLE) w_inst_d[34] = w_mode_d;
    case (w_state_d)
      S_WLOAD: begin
        if (w_i_d < C_ROW) begin
          w_inst_d[19]   = 1'b0;
          w_inst_d[17:7] = w_wb_d + addr_bw'(w_k_d) * addr_bw'(row) + addr_bw'(w_i_d);
        end
        w_inst_d[2] = (w_i_d != '0);
      end
      S_WPUSH: begin
        w_inst_d[0] = 1'b1;
        w_inst_d[3] = (w_i_d < C_ROW);
      end
      S_XLOAD: begin
        if (w_i_d < w_nact_d) begin
          w_inst_d[19]   = 1'b0;
          w_inst_d[17:7] = w_xb_d + addr_bw'(w_i_d);
        end
        w_inst_d[2] = (w_i_d != '0);
      end
      S_EXEC: begin
        w_inst_d[3] = 1'b1;
        w_inst_d[1] = 1'b1;
      end
      S_DRAIN: if (w_drain_rd) begin
        w_inst_d[6]     = 1'b1;
        w_inst_d[32]    = 1'b0;
        w_inst_d[31]    = 1'b0;
        w_inst_d[30:20] = w_pb_d + addr_bw'(r_k) * addr_bw'(w_nact_d) + addr_bw'(r_j);
      end
      S_ACC: begin
        w_inst_d[33]    = 1'b1;
        w_inst_d[32]    = 1'b0;
        w_inst_d[30:20] = w_pb_d + addr_bw'(w_k_d) * addr_bw'(w_nact_d) + addr_bw'(w_i_d);
      end
      default: ;
    endcase
  end

  assign inst = r_inst;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Sequencer that generates the 35-bit instruction word driving one `core` instance (activation/weight SRAM, corelet PE array, OFIFO, psum SRAM, SFP).
- For each kernel position it runs the weight-stationary pass: weight fetch into L0, weight push, activation fetch, execute, OFIFO drain into psum SRAM.
- It then runs the SFP accumulation pass over all stored psums.
- It sits between the host/testbench (start, base addresses) and the core's `inst`/`valid` pins.

Parameters:
- row, 8, PE array rows; weight words per kernel position
- col, 8, PE array columns; extra cycles load is held for weight propagation
- addr_bw, 11, SRAM address width for both memories
- cnt_bw, 11, width of nact and internal counters

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle run request; sampled only in IDLE
- mode  input  1  latched at start, driven on inst[34] for the whole run (0 = WS, 1 = OS)
- kij_num  input  4  kernel positions per run, 1..15; latched at start
- nact  input  cnt_bw  activation vectors per kernel position, ≥1; latched at start
- w_base  input  addr_bw  xmem base address of weights; latched at start
- x_base  input  addr_bw  xmem base address of activations; latched at start
- p_base  input  addr_bw  psum SRAM base address; latched at start
- valid  input  1  core OFIFO has an output vector
- inst  output  35  registered core instruction
- busy  output  1  high from the cycle after an accepted start through DONE
- done  output  1  one-cycle pulse in DONE

Behaviour:
- inst field map:
  - [34] mode; [33] acc
  - [32] psum CEN (active-low); [31] psum WEN (active-low); [30:20] psum address
  - [19] xmem CEN (active-low); [18] xmem WEN (active-low); [17:7] xmem address
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load
- inst is fully registered. Idle/reset value is 35'h1_800C_0000 (both CENs and WENs high, all else 0). busy=0 and done=0 on reset.
- Controller never writes xmem: xmem WEN stays 1. Bits [5] and [4] are always 0.
- States: IDLE, WLOAD, WPUSH, XLOAD, EXEC, DRAIN, ACC, DONE. k = current kernel position; i = phase counter, cleared on every state entry.
- IDLE: start=1 latches the inputs, sets k=0, and enters WLOAD next cycle.
- WLOAD: row+1 cycles.
  - Cycles 0..row-1: xmem CEN=0, address w_base+k*row+i.
  - l0_wr is asserted one cycle after each read (SRAM read latency 1), so it is high for cycles 1..row.
  - Then go to WPUSH.
- WPUSH: row+col cycles with load=1. l0_rd=1 for the first row cycles. Then go to XLOAD.
- XLOAD: nact+1 cycles. Reads x_base+i for i<nact; l0_wr is delayed by one cycle as in WLOAD. Then go to EXEC.
- EXEC: nact cycles with l0_rd=1 and execute=1. Then go to DRAIN with j=0.
- DRAIN: idle inst except as below.
  - valid sampled high in cycle t → in cycle t+1 inst has ofifo_rd=1, psum CEN=0, psum WEN=0, psum address p_base+k*nact+j; j increments.
  - No back-to-back read is issued without valid being re-sampled high.
  - When j reaches nact: k<kij_num-1 → k+1, go to WLOAD; otherwise go to ACC.
- ACC: for o in 0..nact-1, for kk in 0..kij_num-1, one cycle each with psum CEN=0, WEN=1, address p_base+kk*nact+o, acc=1. Total kij_num*nact cycles, then DONE.
- DONE: one cycle with done=1 and inst at idle value, then IDLE.
- Address arithmetic is modulo 2^addr_bw; wrap is silent.
- Degenerate inputs: kij_num=0 treated as 1; nact=0 treated as 1.
- start while busy is ignored; latched values are unchanged.
- Reset asserted in any state: immediately IDLE, inst at idle value, busy=0, done=0, counters cleared. No partial completion.

Test Plan:
- Reset value: hold reset low, toggle clk → inst==35'h1_800C_0000, busy=0, done=0. Release reset, start=0 for 20 cycles → outputs unchanged.
- WLOAD timing: row=col=8, kij_num=1, nact=4, w_base=0, x_base=64, p_base=0, pulse start.
  - xmem addresses 0..7 on 8 consecutive cycles with CEN=0.
  - l0_wr high exactly on the 8 cycles shifted one cycle later.
  - Then load high for 16 cycles.
- EXEC and DRAIN (same run):
  - XLOAD reads addresses 64..67; EXEC holds execute=1 for 4 cycles.
  - valid held high → 4 psum writes to addresses 0..3, each one cycle after a valid sample.
  - ACC reads 0..3 with acc=1; done pulses once.
- Gapped valid: kij_num=2, nact=4, p_base=100, valid toggling 1,0,1,0 in DRAIN.
  - Writes only one cycle after high samples; addresses 100..103, then 104..107.
  - ACC address order: 100,104,101,105,102,106,103,107.
- Mid-run abort: assert reset during EXEC → same cycle inst==35'h1_800C_0000 and busy=0. A new start after release begins WLOAD at w_base with k=0.
- start during busy and mode passthrough: second start mid-run does not change addresses or lengths. mode=1 at start → inst[34]=1 through DONE.
